// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: load/data inputs and segment/digit outputs of the scanner
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     dig;
  logic                  frame_done;
  modport master (output load, data_in, dp_in, blank_lz, input seg, dig, frame_done);
  modport slave  (input load, data_in, dp_in, blank_lz, output seg, dig, frame_done);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed BCD seven-segment scanner with tear-free double-buffered loading
module seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW != 0}};

  logic [CW-1:0]       div_cnt_q, div_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                pend_lz_q, pend_lz_d, disp_lz_q, disp_lz_d;
  logic                pend_valid_q, pend_valid_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                frame_done_q;
  logic                slot_end, boundary, take;
  logic [3:0]          nib;
  logic [7:0]          code;
  logic [DIGITS-1:0]   blank;
  logic                zero_above;

  function automatic logic [7:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0:    seg_code = 8'b11111100;
      4'h1:    seg_code = 8'b01100000;
      4'h2:    seg_code = 8'b11011010;
      4'h3:    seg_code = 8'b11110010;
      4'h4:    seg_code = 8'b01100110;
      4'h5:    seg_code = 8'b10110110;
      4'h6:    seg_code = 8'b10111110;
      4'h7:    seg_code = 8'b11100000;
      4'h8:    seg_code = 8'b11111110;
      4'h9:    seg_code = 8'b11110110;
      4'hA:    seg_code = 8'b00000010;
      default: seg_code = 8'b00000000;
    endcase
  endfunction

  assign slot_end = div_cnt_q == CW'(DIV - 1);
  assign boundary = slot_end && idx_q == IW'(DIGITS - 1);
  assign take     = boundary && (bus.load || pend_valid_q);
  assign nib      = disp_data_q[{idx_q, 2'b00} +: 4];
  assign code     = seg_code(nib);

  // Leading zeros: a digit is blanked while it and every digit above it hold zero
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && disp_data_q[4*i +: 4] == 4'd0;
      blank[i]   = disp_lz_q && zero_above && i != 0;
    end
  end

  // Next state: scan counters, pending buffer, frame-boundary display swap, output image
  always_comb begin
    div_cnt_d    = slot_end ? '0 : div_cnt_q + 1'b1;
    idx_d        = boundary ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
    pend_data_d  = bus.load ? bus.data_in : pend_data_q;
    pend_dp_d    = bus.load ? bus.dp_in : pend_dp_q;
    pend_lz_d    = bus.load ? bus.blank_lz : pend_lz_q;
    pend_valid_d = boundary ? 1'b0 : bus.load | pend_valid_q;
    disp_data_d  = !take ? disp_data_q : bus.load ? bus.data_in : pend_data_q;
    disp_dp_d    = !take ? disp_dp_q : bus.load ? bus.dp_in : pend_dp_q;
    disp_lz_d    = !take ? disp_lz_q : bus.load ? bus.blank_lz : pend_lz_q;
    seg_d        = {blank[idx_q] ? 7'd0 : code[7:1], disp_dp_q[idx_q]} ^ SEG_OFF;
    dig_d        = (div_cnt_q >= CW'(GUARD) ? DIGITS'(1) << idx_q : '0) ^ DIG_OFF;
  end

  // State and registered outputs; reset drops the pins to their inactive level at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_lz_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_lz_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      pend_valid_q <= pend_valid_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_lz_q    <= disp_lz_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= boundary;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig        = dig_q;
  assign bus.frame_done = frame_done_q;
endmodule
